// File: rtl/rt_loader_pkg.sv
// Shared types and constants for the racetrack memory preloader.
// The FSM state enum, port-B drive constants and a counter-width helper live here.
package rt_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_WRITE,
        ST_WAIT_VALID,
        ST_GAP,
        ST_TAIL,
        ST_DONE,
        ST_ERROR
    } ld_state_e;

    localparam logic [31:0] LIM_FUNCT_NOP = '0;
    localparam logic [3:0]  BE_FULL       = 4'hF;
    localparam int          WORD_BYTES    = 4;

    // One counter serves both the rvalid timeout and the tail delay.
    function automatic int cnt_width(input int a, input int b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

endpackage

// File: rtl/rt_byte_packer.sv
// Packs an 8-bit valid/ready stream little-endian into 32-bit words.
// Pulses word_valid_o in the cycle the fourth byte of a word is accepted.
module rt_byte_packer
    import rt_loader_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        collect_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_data_i,
    output logic        byte_ready_o,
    output logic        word_valid_o,
    output logic [31:0] word_o
);

    logic [1:0]  idx_q, idx_d;
    logic [31:0] word_q, word_d;
    logic        accept;

    assign byte_ready_o = collect_i;
    assign accept       = byte_valid_i && collect_i;
    assign word_valid_o = accept && (idx_q == 2'(WORD_BYTES - 1));
    assign word_o       = word_q;

    // A stalled source simply leaves idx_q/word_q untouched.
    always_comb begin
        idx_d  = idx_q;
        word_d = word_q;
        if (accept) begin
            word_d[8*idx_q +: 8] = byte_data_i;
            idx_d                = idx_q + 2'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idx_q  <= '0;
            word_q <= '0;
        end else begin
            idx_q  <= idx_d;
            word_q <= word_d;
        end
    end

endmodule

// File: rtl/rt_mem_loader.sv
// Firmware preloader: streams bytes into 32-bit port-B writes of the racetrack
// LiM memory, then raises a sticky fetch enable for the core.
module rt_mem_loader
    import rt_loader_pkg::*;
#(
    parameter int          ADDR_WIDTH     = 22,
    parameter int          NUM_WORDS      = 4153,
    parameter int unsigned BASE_ADDR      = 0,
    parameter int          FUNCT_WIDTH    = 3,
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter int          TAIL_CYCLES    = 3
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   start_i,
    input  logic                   byte_valid_i,
    input  logic [7:0]             byte_data_i,
    output logic                   byte_ready_o,
    output logic                   mem_en_o,
    output logic                   mem_we_o,
    output logic [3:0]             mem_be_o,
    output logic [ADDR_WIDTH-1:0]  mem_addr_o,
    output logic [31:0]            mem_wdata_o,
    output logic [FUNCT_WIDTH-1:0] mem_lim_funct_o,
    output logic                   mem_we_funct_o,
    output logic [ADDR_WIDTH-1:0]  mem_addr_range_o,
    input  logic                   mem_rvalid_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   error_o,
    output logic [ADDR_WIDTH-1:0]  words_written_o,
    output logic                   fetch_enable_o
);

    localparam int CNT_W = cnt_width(TIMEOUT_CYCLES, TAIL_CYCLES);

    ld_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] words_q, words_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  rvalid_q;
    logic                  rv_edge;
    logic                  collect;
    logic                  word_valid;
    logic [31:0]           word;
    logic                  busy;
    logic                  wr_cycle;

    rt_byte_packer u_packer (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .collect_i    (collect),
        .byte_valid_i (byte_valid_i),
        .byte_data_i  (byte_data_i),
        .byte_ready_o (byte_ready_o),
        .word_valid_o (word_valid),
        .word_o       (word)
    );

    // Only a fresh rising edge completes a write; a held-high level does not.
    assign rv_edge = mem_rvalid_i && !rvalid_q;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        words_d  = words_q;
        cnt_d    = cnt_q;
        busy     = 1'b0;
        collect  = 1'b0;
        wr_cycle = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (NUM_WORDS == 0) begin
                        state_d = ST_TAIL;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_COLLECT;
                    end
                end
            end
            ST_COLLECT: begin
                busy    = 1'b1;
                collect = 1'b1;
                if (word_valid) state_d = ST_WRITE;
            end
            ST_WRITE: begin
                busy     = 1'b1;
                wr_cycle = 1'b1;
                // The WRITE cycle counts as the first cycle of the timeout window.
                cnt_d    = CNT_W'(1);
                state_d  = ST_WAIT_VALID;
            end
            ST_WAIT_VALID: begin
                busy = 1'b1;
                if (rv_edge) begin
                    state_d = ST_GAP;
                end else if (int'(cnt_q) + 1 >= TIMEOUT_CYCLES) begin
                    state_d = ST_ERROR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_GAP: begin
                busy    = 1'b1;
                addr_d  = addr_q + ADDR_WIDTH'(WORD_BYTES);
                words_d = words_q + ADDR_WIDTH'(1);
                if (words_d == ADDR_WIDTH'(NUM_WORDS)) begin
                    state_d = ST_TAIL;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_COLLECT;
                end
            end
            ST_TAIL: begin
                busy = 1'b1;
                if (int'(cnt_q) + 1 >= TAIL_CYCLES) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE:  ;
            ST_ERROR: ;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            addr_q   <= ADDR_WIDTH'(BASE_ADDR);
            words_q  <= '0;
            cnt_q    <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            words_q  <= words_d;
            cnt_q    <= cnt_d;
            rvalid_q <= mem_rvalid_i;
        end
    end

    // Port B is fully quiet whenever the loader does not own it.
    assign busy_o           = busy;
    assign mem_en_o         = wr_cycle;
    assign mem_we_o         = wr_cycle;
    assign mem_be_o         = wr_cycle ? BE_FULL : 4'h0;
    assign mem_addr_o       = busy ? addr_q : '0;
    assign mem_wdata_o      = busy ? word : '0;
    assign mem_lim_funct_o  = FUNCT_WIDTH'(LIM_FUNCT_NOP);
    assign mem_we_funct_o   = 1'b0;
    assign mem_addr_range_o = '0;

    assign done_o          = (state_q == ST_DONE);
    assign error_o         = (state_q == ST_ERROR);
    assign fetch_enable_o  = (state_q == ST_DONE);
    assign words_written_o = words_q;

endmodule

// File: tb/tb_rt_mem_loader.sv
// Directed bench for rt_mem_loader: instance 0 is a 3-word, 22-bit loader with a
// 16-cycle timeout; instance 1 is a 4-bit address loader starting at 0xC.
module tb_rt_mem_loader;

    localparam int AW = 22;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]      rst_n, start, bvalid, hold;
    logic [1:0][7:0] bdata;
    wire  [1:0]      rvalid, ready, en, we, busy, done, err, fe, wef;
    wire  [1:0][3:0] be;
    wire  [1:0][31:0] wdata;
    wire  [1:0][AW-1:0] addr, words, rng;
    wire  [1:0][2:0] funct;
    wire  [3:0]      b_addr, b_words, b_rng;

    assign addr[1]  = {18'd0, b_addr};
    assign words[1] = {18'd0, b_words};
    assign rng[1]   = {18'd0, b_rng};

    int         mode [2] = '{0, 0};   // 0: rvalid 3 cycles after en, 1: never, 2: bench-held level
    logic [2:0] sr   [2] = '{default: 3'b0};
    int         en_cnt [2] = '{0, 0};
    int         lim_bad = 0;
    int         n_chk = 0;
    int         n_fail = 0;

    for (genvar g = 0; g < 2; g++) begin : g_rv
        assign rvalid[g] = (mode[g] == 0) ? sr[g][2] : (mode[g] == 2) ? hold[g] : 1'b0;
    end

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            sr[k] <= {sr[k][1:0], en[k]};
            if (en[k]) en_cnt[k] <= en_cnt[k] + 1;
        end
        if (funct != '0 || wef != '0 || rng != '0) lim_bad <= lim_bad + 1;
    end

    rt_mem_loader #(
        .ADDR_WIDTH(AW), .NUM_WORDS(3), .BASE_ADDR(0), .FUNCT_WIDTH(3),
        .TIMEOUT_CYCLES(16), .TAIL_CYCLES(3)
    ) u_dut (
        .clk_i(clk), .rst_ni(rst_n[0]), .start_i(start[0]),
        .byte_valid_i(bvalid[0]), .byte_data_i(bdata[0]), .byte_ready_o(ready[0]),
        .mem_en_o(en[0]), .mem_we_o(we[0]), .mem_be_o(be[0]), .mem_addr_o(addr[0]),
        .mem_wdata_o(wdata[0]), .mem_lim_funct_o(funct[0]), .mem_we_funct_o(wef[0]),
        .mem_addr_range_o(rng[0]), .mem_rvalid_i(rvalid[0]), .busy_o(busy[0]),
        .done_o(done[0]), .error_o(err[0]), .words_written_o(words[0]),
        .fetch_enable_o(fe[0])
    );

    rt_mem_loader #(
        .ADDR_WIDTH(4), .NUM_WORDS(2), .BASE_ADDR(12), .FUNCT_WIDTH(3),
        .TIMEOUT_CYCLES(16), .TAIL_CYCLES(3)
    ) u_wrap (
        .clk_i(clk), .rst_ni(rst_n[1]), .start_i(start[1]),
        .byte_valid_i(bvalid[1]), .byte_data_i(bdata[1]), .byte_ready_o(ready[1]),
        .mem_en_o(en[1]), .mem_we_o(we[1]), .mem_be_o(be[1]), .mem_addr_o(b_addr),
        .mem_wdata_o(wdata[1]), .mem_lim_funct_o(funct[1]), .mem_we_funct_o(wef[1]),
        .mem_addr_range_o(b_rng), .mem_rvalid_i(rvalid[1]), .busy_o(busy[1]),
        .done_o(done[1]), .error_o(err[1]), .words_written_o(b_words),
        .fetch_enable_o(fe[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int i);
        rst_n[i]  = 1'b0;
        start[i]  = 1'b0;
        bvalid[i] = 1'b0;
        tick();
        tick();
        rst_n[i] = 1'b1;
        tick();
    endtask

    task automatic start_load(input int i);
        start[i] = 1'b1;
        tick();
        start[i] = 1'b0;
    endtask

    task automatic send_byte(input int i, input logic [7:0] b);
        logic acc;
        acc       = 1'b0;
        bvalid[i] = 1'b1;
        bdata[i]  = b;
        for (int n = 0; n < 50 && !acc; n++) begin
            acc = ready[i];
            tick();
        end
        bvalid[i] = 1'b0;
        chk("byte_accept", {31'd0, acc}, 32'd1);
    endtask

    // Returns sampled in the WRITE cycle.
    task automatic send_word(input int i, input logic [31:0] w);
        for (int k = 0; k < 4; k++) send_byte(i, w[8*k +: 8]);
    endtask

    task automatic wait_words(input int i, input logic [AW-1:0] prev);
        for (int n = 0; n < 60 && words[i] == prev; n++) tick();
    endtask

    initial begin
        time t0;
        int  e0, lows, early;

        rst_n = '0; start = '0; bvalid = '0; bdata = '0; hold = '0;
        tick();
        tick();

        // Reset state
        chk("rst_flags", {25'd0, busy[0], done[0], err[0], fe[0], ready[0], en[0], we[0]}, 0);
        chk("rst_addr", addr[0], 0);
        chk("rst_words", words[0], 0);
        chk("rst_wdata", wdata[0], 0);
        rst_n[0] = 1'b1;
        tick();

        // Bytes offered in IDLE are not consumed
        bvalid[0] = 1'b1; bdata[0] = 8'hAA;
        tick();
        tick();
        chk("idle_ready", {31'd0, ready[0]}, 0);
        bvalid[0] = 1'b0;

        // Main image: three words, rvalid 3 cycles after en
        e0 = en_cnt[0];
        start_load(0);
        chk("busy_after_start", {31'd0, busy[0]}, 1);
        send_word(0, 32'h12345678);
        chk("w1_strobe", {26'd0, en[0], we[0], be[0]}, 32'h3F);
        chk("w1_addr", addr[0], 0);
        chk("w1_data", wdata[0], 32'h12345678);
        chk("w1_lim", {funct[0], wef[0], rng[0][5:0]}, 0);
        t0 = $time;
        tick();
        chk("w1_wait_en", {30'd0, en[0], ready[0]}, 0);
        chk("w1_wait_data", wdata[0], 32'h12345678);
        wait_words(0, 0);
        chk("w1_period", 32'(($time - t0) / 10), 5);
        chk("w1_count", words[0], 1);
        chk("w2_addr_pre", addr[0], 4);
        send_word(0, 32'hDEADBEEF);
        chk("w2_addr", addr[0], 4);
        chk("w2_data", wdata[0], 32'hDEADBEEF);
        wait_words(0, 1);
        send_word(0, 32'hCAFEF00D);
        chk("w3_addr", addr[0], 8);
        chk("w3_data", wdata[0], 32'hCAFEF00D);
        wait_words(0, 2);
        chk("tail_start", {30'd0, done[0], busy[0]}, 1);
        tick();
        tick();
        chk("tail_end_not_done", {31'd0, done[0]}, 0);
        tick();
        chk("done_flags", {28'd0, done[0], fe[0], busy[0], en[0]}, 32'hC);
        chk("done_addr_quiet", addr[0], 0);
        chk("done_words", words[0], 3);
        chk("en_cycles", 32'(en_cnt[0] - e0), 3);
        start_load(0);
        chk("done_sticky", {30'd0, done[0], busy[0]}, 2);

        // Source stall between bytes 2 and 3
        do_reset(0);
        start_load(0);
        send_byte(0, 8'h78);
        send_byte(0, 8'h56);
        lows = 0;
        for (int n = 0; n < 10; n++) begin
            if (!ready[0]) lows++;
            tick();
        end
        chk("stall_ready", 32'(lows), 0);
        send_byte(0, 8'h34);
        send_byte(0, 8'h12);
        chk("stall_data", wdata[0], 32'h12345678);
        wait_words(0, 0);
        chk("stall_words", words[0], 1);
        chk("stall_err", {31'd0, err[0]}, 0);

        // rvalid held high across two writes
        do_reset(0);
        mode[0] = 2; hold[0] = 1'b0;
        start_load(0);
        send_word(0, 32'h11223344);
        tick();
        tick();
        hold[0] = 1'b1;
        wait_words(0, 0);
        chk("hold_w1", words[0], 1);
        send_word(0, 32'h55667788);
        chk("hold_w2_en", {31'd0, en[0]}, 1);
        early = 0;
        for (int n = 0; n < 6; n++) begin
            tick();
            if (words[0] != 1 || !busy[0]) early++;
        end
        chk("hold_no_early_gap", 32'(early), 0);
        hold[0] = 1'b0;
        tick();
        hold[0] = 1'b1;
        wait_words(0, 1);
        chk("hold_w2", words[0], 2);
        chk("hold_err", {31'd0, err[0]}, 0);

        // rvalid never arrives
        do_reset(0);
        mode[0] = 1;
        start_load(0);
        send_word(0, 32'hA5A5A5A5);
        t0 = $time;
        for (int n = 0; n < 40 && !err[0]; n++) tick();
        chk("tmo_cycles", 32'(($time - t0) / 10), 16);
        chk("tmo_flags", {27'd0, err[0], busy[0], fe[0], done[0], en[0]}, 32'h10);
        start_load(0);
        chk("tmo_sticky", {29'd0, err[0], busy[0], fe[0]}, 4);

        // Reset in WAIT_VALID of word 3
        do_reset(0);
        mode[0] = 0;
        start_load(0);
        send_word(0, 32'h01010101);
        wait_words(0, 0);
        send_word(0, 32'h02020202);
        wait_words(0, 1);
        send_word(0, 32'h0BADF00D);
        tick();
        tick();
        rst_n[0] = 1'b0;
        #1;
        chk("arst_flags", {28'd0, busy[0], en[0], ready[0], fe[0]}, 0);
        chk("arst_addr", addr[0], 0);
        chk("arst_words", words[0], 0);
        chk("arst_wdata", wdata[0], 0);
        #2;
        rst_n[0] = 1'b1;
        tick();
        start_load(0);
        send_word(0, 32'h33333333);
        chk("restart_addr", addr[0], 0);
        chk("restart_words", words[0], 0);
        wait_words(0, 0);
        chk("restart_w1", words[0], 1);

        // Address wrap on the 4-bit instance
        do_reset(1);
        start_load(1);
        send_word(1, 32'h01020304);
        chk("wrap_w1_addr", addr[1], 32'hC);
        wait_words(1, 0);
        send_word(1, 32'h05060708);
        chk("wrap_w2_addr", addr[1], 0);
        chk("wrap_w2_data", wdata[1], 32'h05060708);
        wait_words(1, 1);
        tick();
        tick();
        tick();
        chk("wrap_done", {30'd0, done[1], fe[1]}, 3);
        chk("lim_always_zero", 32'(lim_bad), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
